alu_operand_issue: RTL and testbench

- Issue/operand stage that drives the ALU's input interface: `reg_A`, `reg_B`, `ex_ir` and `cf_in`.
- Accepts decoded instruction words from fetch over a valid/ready handshake and reads an 8x16 register file.
- Resolves read-after-write hazards with a pending-write scoreboard, stalling fetch when a source is not yet available.
- Registers the ALU operands and holds the carry flag fed back from ALU `cf_out`.

---
 rtl/alu_operand_issue_if.sv | 32 +++
 rtl/alu_operand_issue.sv | 118 +++++++++++
 tb/tb_alu_operand_issue.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_operand_issue_if.sv
// Issue-stage bus bundle.
//   Fetch side    : in_ir, in_valid, in_ready, flush
//   Writeback side: wb_en, wb_addr, wb_data
//   ALU side      : reg_A, reg_B, ex_ir, ex_valid, cf_in, cf_out
// master = environment (fetch/writeback/ALU), slave = alu_operand_issue.
interface alu_operand_issue_if #(
  parameter int DW = 16
);
  logic [DW-1:0] in_ir;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic          wb_en;
  logic [2:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          cf_out;
  logic [DW-1:0] reg_A;
  logic [DW-1:0] reg_B;
  logic [DW-1:0] ex_ir;
  logic          ex_valid;
  logic          cf_in;

  modport master (
    output in_ir, in_valid, flush, wb_en, wb_addr, wb_data, cf_out,
    input  in_ready, reg_A, reg_B, ex_ir, ex_valid, cf_in
  );

  modport slave (
    input  in_ir, in_valid, flush, wb_en, wb_addr, wb_data, cf_out,
    output in_ready, reg_A, reg_B, ex_ir, ex_valid, cf_in
  );
endinterface

// File: rtl/alu_operand_issue.sv
// Issue/operand stage feeding the ALU.
// Accepts decoded instructions from fetch (valid/ready), reads an 8x16
// register file with write-through bypass, stalls on read-after-write
// hazards via a pending-write scoreboard, registers operands and EX
// instruction, and holds the carry flag returned by the ALU.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : alu_operand_issue_if.slave (fetch, writeback and ALU signals)
module alu_operand_issue #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input logic                clock,
  input logic                reset,
  alu_operand_issue_if.slave bus
);

  localparam int AW = 3;

  logic [DW-1:0]   rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic [4:0]      op;
  logic [AW-1:0]   r1;
  logic [AW-1:0]   r2;
  logic [AW-1:0]   r3;
  logic [AW-1:0]   addr_a;
  logic [DW-1:0]   rd_a;
  logic [DW-1:0]   rd_b;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic            writes_dest;
  logic            use_a;
  logic            use_b;
  logic            stall_a;
  logic            stall_b;
  logic            hazard;
  logic            issue;

  logic [DW-1:0]   reg_a_q;
  logic [DW-1:0]   reg_b_q;
  logic [DW-1:0]   ex_ir_q;
  logic            ex_valid_q;
  logic            cf_q;

  always_comb begin
    op     = bus.in_ir[15:11];
    r1     = bus.in_ir[10:8];
    r2     = bus.in_ir[6:4];
    r3     = bus.in_ir[2:0];

    // Reg-imm ALU ops read their destination; everything else reads r2.
    addr_a = (op[4:3] == 2'b11) ? r1 : r2;

    rd_a   = (bus.wb_en && bus.wb_addr == addr_a) ? bus.wb_data : rf[addr_a];
    rd_b   = (bus.wb_en && bus.wb_addr == r3)     ? bus.wb_data : rf[r3];

    sel_a  = rd_a;
    sel_b  = {12'h000, bus.in_ir[3:0]};
    if (op[4:3] == 2'b10)      sel_b = rd_b;
    else if (op[4:3] == 2'b11) sel_b = {8'h00, bus.in_ir[7:0]};

    writes_dest = op[4] || (op == 5'b00010);
    use_a       = (bus.in_ir != '0);
    use_b       = use_a && (op[4:3] == 2'b10);

    // A result arriving on writeback this cycle satisfies the read.
    stall_a = busy[addr_a] && !(bus.wb_en && bus.wb_addr == addr_a);
    stall_b = busy[r3]     && !(bus.wb_en && bus.wb_addr == r3);
    hazard  = (use_a && stall_a) || (use_b && stall_b);

    bus.in_ready = !hazard && !bus.flush;
    issue        = bus.in_valid && bus.in_ready;

    // Clear first so a same-cycle set on the same bit takes priority.
    busy_nxt = busy;
    if (bus.wb_en)            busy_nxt[bus.wb_addr] = 1'b0;
    if (issue && writes_dest) busy_nxt[r1]          = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      busy       <= '0;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      ex_ir_q    <= '0;
      ex_valid_q <= 1'b0;
      cf_q       <= 1'b0;
    end else begin
      if (bus.wb_en) rf[bus.wb_addr] <= bus.wb_data;
      busy <= busy_nxt;
      if (issue) begin
        reg_a_q    <= sel_a;
        reg_b_q    <= sel_b;
        ex_ir_q    <= bus.in_ir;
        ex_valid_q <= 1'b1;
      end else begin
        reg_a_q    <= '0;
        reg_b_q    <= '0;
        ex_ir_q    <= '0;
        ex_valid_q <= 1'b0;
      end
      if (ex_valid_q && ex_ir_q[15]) cf_q <= bus.cf_out;
    end
  end

  always_comb begin
    bus.reg_A    = reg_a_q;
    bus.reg_B    = reg_b_q;
    bus.ex_ir    = ex_ir_q;
    bus.ex_valid = ex_valid_q;
    bus.cf_in    = cf_q;
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: stimulus pushes hand-computed
// EX-stage expectations into a queue; a monitor pops and compares them
// one cycle after each accepting edge.
module tb_alu_operand_issue;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] a;
    logic [15:0] b;
    logic        v;
    logic        cf;
  } exp_t;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  alu_operand_issue_if #(.DW(16)) bus ();

  alu_operand_issue #(.NREG(8), .DW(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One cycle of stimulus, driven from a negedge.
  task automatic step(input logic [15:0] ir, input logic valid, input logic fl,
                      input logic wen, input logic [2:0] waddr, input logic [15:0] wdata,
                      input logic cfo, input logic rdy,
                      input logic [15:0] e_ir, input logic [15:0] e_a, input logic [15:0] e_b,
                      input logic e_v, input logic e_cf);
    exp_t e;
    bus.in_ir    = ir;
    bus.in_valid = valid;
    bus.flush    = fl;
    bus.wb_en    = wen;
    bus.wb_addr  = waddr;
    bus.wb_data  = wdata;
    bus.cf_out   = cfo;
    #1;
    chk("in_ready", {15'd0, bus.in_ready}, {15'd0, rdy});
    e.ir = e_ir; e.a = e_a; e.b = e_b; e.v = e_v; e.cf = e_cf;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_reg_A"},    bus.reg_A, 16'h0000);
    chk({tag, "_reg_B"},    bus.reg_B, 16'h0000);
    chk({tag, "_ex_ir"},    bus.ex_ir, 16'h0000);
    chk({tag, "_ex_valid"}, {15'd0, bus.ex_valid}, 16'h0000);
    chk({tag, "_cf_in"},    {15'd0, bus.cf_in}, 16'h0000);
  endtask

  // Monitor: compares EX outputs after every edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_ir",    bus.ex_ir, e.ir);
        chk("reg_A",    bus.reg_A, e.a);
        chk("reg_B",    bus.reg_B, e.b);
        chk("ex_valid", {15'd0, bus.ex_valid}, {15'd0, e.v});
        chk("cf_in",    {15'd0, bus.cf_in}, {15'd0, e.cf});
      end
    end
  end

  initial begin
    bus.in_ir = '0; bus.in_valid = 1'b0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.cf_out = 1'b0;
    reset = 1'b0;
    #2;
    chk_zero_outputs("rst");
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'h0001);
    @(negedge clock);
    reset = 1'b1;

    //   ir        vld fl wen ad wdata    cfo rdy  e_ir      e_a       e_b       v  cf
    step(16'h0000, 0, 0, 1, 1, 16'h0001, 0,  1,  16'h0000, 16'h0000, 16'h0000, 0, 0);
    step(16'h0000, 0, 0, 1, 2, 16'h0001, 0,  1,  16'h0000, 16'h0000, 16'h0000, 0, 0);
    // reg-reg r1=3 r2=1 r3=2; marks r3 busy
    step(16'h8312, 1, 0, 0, 0, 16'h0000, 0,  1,  16'h8312, 16'h0001, 16'h0001, 1, 0);
    // reads r3 while busy -> stall; ALU in EX returns carry 1
    step(16'h8431, 1, 0, 0, 0, 16'h0000, 1,  0,  16'h0000, 16'h0000, 16'h0000, 0, 1);
    // writeback of r3 releases the stall in the same cycle via bypass
    step(16'h8431, 1, 0, 1, 3, 16'h00AB, 0,  1,  16'h8431, 16'h00AB, 16'h0001, 1, 1);
    // load r6 <- [r5 + 3]
    step(16'h1653, 1, 0, 0, 0, 16'h0000, 1,  1,  16'h1653, 16'h0000, 16'h0003, 1, 1);
    // load in EX with cf_out=0: carry holds
    step(16'h0000, 0, 0, 1, 5, 16'h1234, 0,  1,  16'h0000, 16'h0000, 16'h0000, 0, 1);
    // reg-imm on r5
    step(16'hC5F0, 1, 0, 0, 0, 16'h0000, 0,  1,  16'hC5F0, 16'h1234, 16'h00F0, 1, 1);
    // flush kills an otherwise-issuable instruction; ALU carry 0 lands
    step(16'h8312, 1, 1, 0, 0, 16'h0000, 0,  0,  16'h0000, 16'h0000, 16'h0000, 0, 0);
    // r4 still busy from the earlier reg-reg issue
    step(16'h8040, 1, 0, 0, 0, 16'h0000, 1,  0,  16'h0000, 16'h0000, 16'h0000, 0, 0);
    // writeback r4 while issuing a new writer of r4: bit must stay set
    step(16'hC401, 1, 0, 1, 4, 16'h0055, 0,  1,  16'hC401, 16'h0055, 16'h0001, 1, 0);
    step(16'h8040, 1, 0, 0, 0, 16'h0000, 0,  0,  16'h0000, 16'h0000, 16'h0000, 0, 0);
    // writeback to an unrelated register does not unblock r4
    step(16'h8040, 1, 0, 1, 2, 16'h0007, 0,  0,  16'h0000, 16'h0000, 16'h0000, 0, 0);
    step(16'h8312, 1, 0, 0, 0, 16'h0000, 0,  1,  16'h8312, 16'h0001, 16'h0007, 1, 0);

    // Reset while a reader of busy r3 is stalled
    bus.in_ir = 16'h8431; bus.in_valid = 1'b1; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.cf_out = 1'b1;
    #1;
    chk("stall_before_reset", {15'd0, bus.in_ready}, 16'h0000);
    reset = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    // busy and register file cleared: issues with zero operands
    step(16'h8431, 1, 0, 0, 0, 16'h0000, 0,  1,  16'h8431, 16'h0000, 16'h0000, 1, 0);

    chk("queue_drained", exp_q.size()[15:0], 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
